// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: symbolic op codes for the loader and the
// fixed opcode fields common to the control decoder.
package legv8_pkg;

   typedef enum logic [3:0] {
      OP_ADDI  = 4'd0,
      OP_ADDS  = 4'd1,
      OP_SUBS  = 4'd2,
      OP_B     = 4'd3,
      OP_BLT   = 4'd4,
      OP_CBZ   = 4'd5,
      OP_LDUR  = 4'd6,
      OP_STUR  = 4'd7,
      OP_LDURB = 4'd8,
      OP_STURB = 4'd9,
      OP_LSL   = 4'd10,
      OP_LSR   = 4'd11,
      OP_MOVZ  = 4'd12,
      OP_MOVK  = 4'd13,
      OP_END   = 4'd14
   } op_e;

   localparam logic [9:0]  ADDI  = 10'b1001000100;
   localparam logic [10:0] ADDS  = 11'b10101011000;
   localparam logic [10:0] SUBS  = 11'b11101011000;
   localparam logic [5:0]  B     = 6'b000101;
   localparam logic [7:0]  BLT   = 8'b01010100;
   localparam logic [7:0]  CBZ   = 8'b10110100;
   localparam logic [10:0] LDUR  = 11'b11111000010;
   localparam logic [10:0] STUR  = 11'b11111000000;
   localparam logic [10:0] LDURB = 11'b00111000010;
   localparam logic [10:0] STURB = 11'b00111000000;
   localparam logic [10:0] LSL   = 11'b11010011011;
   localparam logic [10:0] LSR   = 11'b11010011010;
   localparam logic [8:0]  MOVZ  = 9'b110100101;
   localparam logic [8:0]  MOVK  = 9'b111100101;

   localparam logic [4:0]  COND_LT = 5'b01011;

   // True when v is representable as a two's-complement value of 'bits' bits.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i >= bits - 1 && v[i] != v[31]) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/legv8_instr_encode.sv
// Combinational LEGv8 instruction encoder with operand range checking.
module legv8_instr_encode
   import legv8_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rn,
   input  logic [4:0]  rm,
   input  logic [31:0] imm,
   input  logic [5:0]  aux,
   output logic [31:0] word,
   output logic        imm_bad,
   output logic        op_bad
);

   op_e op_s;
   assign op_s = op_e'(op);

   always_comb begin
      word    = '0;
      imm_bad = 1'b0;
      op_bad  = 1'b0;
      case (op_s)
         OP_ADDI: begin
            word    = {ADDI, imm[11:0], rn, rd};
            imm_bad = |imm[31:12];
         end
         OP_ADDS:  word = {ADDS, rm, 6'd0, rn, rd};
         OP_SUBS:  word = {SUBS, rm, 6'd0, rn, rd};
         OP_LSL:   word = {LSL, 5'd0, aux, rn, rd};
         OP_LSR:   word = {LSR, 5'd0, aux, rn, rd};
         OP_LDUR: begin
            word    = {LDUR, imm[8:0], 2'b00, rn, rd};
            imm_bad = !fits_signed(imm, 9);
         end
         OP_STUR: begin
            word    = {STUR, imm[8:0], 2'b00, rn, rd};
            imm_bad = !fits_signed(imm, 9);
         end
         OP_LDURB: begin
            word    = {LDURB, imm[8:0], 2'b00, rn, rd};
            imm_bad = !fits_signed(imm, 9);
         end
         OP_STURB: begin
            word    = {STURB, imm[8:0], 2'b00, rn, rd};
            imm_bad = !fits_signed(imm, 9);
         end
         OP_B: begin
            word    = {B, imm[25:0]};
            imm_bad = !fits_signed(imm, 26);
         end
         OP_CBZ: begin
            word    = {CBZ, imm[18:0], rd};
            imm_bad = !fits_signed(imm, 19);
         end
         OP_BLT: begin
            word    = {BLT, imm[18:0], COND_LT};
            imm_bad = !fits_signed(imm, 19);
         end
         OP_MOVZ: begin
            word    = {MOVZ, aux[1:0], imm[15:0], rd};
            imm_bad = |imm[31:16] || |aux[5:2];
         end
         OP_MOVK: begin
            word    = {MOVK, aux[1:0], imm[15:0], rd};
            imm_bad = |imm[31:16] || |aux[5:2];
         end
         OP_END: ;
         default: op_bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/legv8_prog_loader.sv
// Program loader: accepts symbolic requests, encodes them and writes the
// words sequentially into instruction memory, one cycle after each transfer.
module legv8_prog_loader
   import legv8_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned DEPTH     = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rn,
   input  logic [4:0]        req_rm,
   input  logic [31:0]       req_imm,
   input  logic [5:0]        req_aux,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   words_written,
   output logic              busy,
   output logic              done,
   output logic              full,
   output logic              err_imm,
   output logic              err_op
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);

   state_e            state;
   logic [ADDR_W-1:0] ptr;
   logic [31:0]       enc_word;
   logic              enc_imm_bad;
   logic              enc_op_bad;
   logic              xfer;

   legv8_instr_encode u_encode (
      .op      (req_op),
      .rd      (req_rd),
      .rn      (req_rn),
      .rm      (req_rm),
      .imm     (req_imm),
      .aux     (req_aux),
      .word    (enc_word),
      .imm_bad (enc_imm_bad),
      .op_bad  (enc_op_bad)
   );

   assign xfer = req_valid && req_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         ptr           <= BASE;
         req_ready     <= 1'b0;
         imem_we       <= 1'b0;
         imem_addr     <= '0;
         imem_wdata    <= '0;
         words_written <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         full          <= 1'b0;
         err_imm       <= 1'b0;
         err_op        <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state         <= LOAD;
                  ptr           <= BASE;
                  words_written <= '0;
                  err_imm       <= 1'b0;
                  err_op        <= 1'b0;
                  done          <= 1'b0;
                  full          <= 1'b0;
                  busy          <= 1'b1;
                  req_ready     <= 1'b1;
               end
            end
            LOAD: begin
               if (xfer) begin
                  if (enc_op_bad) begin
                     err_op <= 1'b1;
                  end else if (op_e'(req_op) == OP_END) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     req_ready <= 1'b0;
                  end else if (enc_imm_bad) begin
                     err_imm <= 1'b1;
                  end else begin
                     imem_we       <= 1'b1;
                     imem_addr     <= ptr;
                     imem_wdata    <= enc_word;
                     ptr           <= ptr + 1'b1;
                     words_written <= words_written + 1'b1;
                     // Ready drops with the final write so no further request slips in.
                     if (words_written + 1'b1 == DEPTH_W) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        full      <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b0;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_legv8_prog_loader.sv
// Self-checking bench for legv8_prog_loader: directed encodings, error and
// full handling, randomized sessions against a reference model, and reset.
module tb_legv8_prog_loader;

   localparam int unsigned ADDR_W_T = 6;
   localparam int unsigned BASE_T   = 9;
   localparam int unsigned DEPTH_T  = 4;

   localparam int T_ADDI = 0,  T_ADDS = 1,  T_SUBS = 2,  T_B = 3,     T_BLT = 4;
   localparam int T_CBZ  = 5,  T_LDUR = 6,  T_STUR = 7,  T_LDURB = 8, T_STURB = 9;
   localparam int T_LSL  = 10, T_LSR = 11,  T_MOVZ = 12, T_MOVK = 13, T_END = 14;
   localparam int T_BAD  = 15;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                start;
   logic                req_valid;
   logic                req_ready;
   logic [3:0]          req_op;
   logic [4:0]          req_rd, req_rn, req_rm;
   logic [31:0]         req_imm;
   logic [5:0]          req_aux;
   logic                imem_we;
   logic [ADDR_W_T-1:0] imem_addr;
   logic [31:0]         imem_wdata;
   logic [ADDR_W_T:0]   words_written;
   logic                busy, done, full, err_imm, err_op;

   int checks   = 0;
   int failures = 0;

   // Reference model state: 0 = idle, 1 = loading, 2 = finished
   int          m_state;
   int unsigned m_ptr, m_cnt, m_addr;
   bit          m_we, m_full, m_eimm, m_eop;
   logic [31:0] m_wdata;

   legv8_prog_loader #(.ADDR_W(ADDR_W_T), .BASE_ADDR(BASE_T), .DEPTH(DEPTH_T)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm),
      .req_imm(req_imm), .req_aux(req_aux),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .words_written(words_written), .busy(busy), .done(done), .full(full),
      .err_imm(err_imm), .err_op(err_op)
   );

   always #5 clk = ~clk;

   function automatic void ref_encode(input int op, input int unsigned rd, input int unsigned rn,
                                      input int unsigned rm, input logic [31:0] imm,
                                      input int unsigned aux, output logic [31:0] w, output bit bad);
      longint s, u;
      s = longint'($signed(imm));
      u = longint'(imm);
      w = '0;
      bad = 0;
      case (op)
         T_ADDI: begin bad = u > 4095; w = (32'h244 << 22) | ((imm & 32'hFFF) << 10) | (rn << 5) | rd; end
         T_ADDS: w = (32'h558 << 21) | (rm << 16) | (rn << 5) | rd;
         T_SUBS: w = (32'h758 << 21) | (rm << 16) | (rn << 5) | rd;
         T_B: begin
            bad = s < -(longint'(1) << 25) || s > (longint'(1) << 25) - 1;
            w = (32'h05 << 26) | (imm & 32'h03FF_FFFF);
         end
         T_BLT, T_CBZ: begin
            bad = s < -(longint'(1) << 18) || s > (longint'(1) << 18) - 1;
            w = ((op == T_BLT ? 32'h54 : 32'hB4) << 24) | ((imm & 32'h7FFFF) << 5)
                | (op == T_BLT ? 32'd11 : 32'(rd));
         end
         T_LDUR, T_STUR, T_LDURB, T_STURB: begin
            bad = s < -256 || s > 255;
            w = ((op == T_LDUR) ? 32'h7C2 : (op == T_STUR) ? 32'h7C0 : (op == T_LDURB) ? 32'h1C2 : 32'h1C0) << 21;
            w = w | ((imm & 32'h1FF) << 12) | (rn << 5) | rd;
         end
         T_LSL, T_LSR: begin
            bad = aux > 63;
            w = ((op == T_LSL ? 32'h69B : 32'h69A) << 21) | (aux << 10) | (rn << 5) | rd;
         end
         T_MOVZ, T_MOVK: begin
            bad = u > 65535 || aux > 3;
            w = ((op == T_MOVZ ? 32'h1A5 : 32'h1E5) << 23) | ((aux & 3) << 21) | ((imm & 32'hFFFF) << 5) | rd;
         end
         default: ;
      endcase
   endfunction

   function automatic void model_reset();
      m_state = 0; m_ptr = BASE_T; m_cnt = 0; m_addr = 0; m_wdata = '0;
      m_we = 0; m_full = 0; m_eimm = 0; m_eop = 0;
   endfunction

   function automatic void model_step();
      logic [31:0] w;
      bit bad;
      m_we = 0;
      if (!reset_n) begin
         model_reset();
      end else if (m_state != 1) begin
         if (start) begin
            m_state = 1; m_ptr = BASE_T; m_cnt = 0; m_full = 0; m_eimm = 0; m_eop = 0;
         end
      end else if (req_valid) begin
         if (req_op == 4'(T_BAD)) m_eop = 1;
         else if (req_op == 4'(T_END)) m_state = 2;
         else begin
            ref_encode(int'(req_op), req_rd, req_rn, req_rm, req_imm, req_aux, w, bad);
            if (bad) m_eimm = 1;
            else begin
               m_we = 1; m_addr = m_ptr; m_wdata = w; m_ptr++; m_cnt++;
               if (m_cnt == DEPTH_T) begin m_state = 2; m_full = 1; end
            end
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input int op, input int unsigned rd, input int unsigned rn,
                        input int unsigned rm, input logic [31:0] imm, input int unsigned aux);
      req_valid = 1'b1;
      req_op = 4'(op); req_rd = 5'(rd); req_rn = 5'(rn); req_rm = 5'(rm);
      req_imm = imm; req_aux = 6'(aux);
   endtask

   function automatic logic [31:0] rand_imm(input int op);
      longint lo, hi, v;
      case (op)
         T_B:                               begin lo = -(longint'(1) << 25); hi = (longint'(1) << 25) - 1; end
         T_BLT, T_CBZ:                      begin lo = -(longint'(1) << 18); hi = (longint'(1) << 18) - 1; end
         T_LDUR, T_STUR, T_LDURB, T_STURB:  begin lo = -256; hi = 255; end
         T_MOVZ, T_MOVK:                    begin lo = 0; hi = 65535; end
         default:                           begin lo = 0; hi = 4095; end
      endcase
      case ($urandom_range(0, 7))
         0: v = lo;
         1: v = hi;
         2: v = lo - 1;
         3: v = hi + 1;
         4: v = longint'($urandom);
         default: v = lo + longint'($urandom_range(0, 32'(hi - lo)));
      endcase
      return 32'(v);
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; req_valid = 1'b0;
      req_op = '0; req_rd = '0; req_rn = '0; req_rm = '0; req_imm = '0; req_aux = '0;
      model_reset();
      #12;
      checks++;
      if ({imem_we, req_ready, busy, done, full, err_imm, err_op} !== 7'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000000", {imem_we, req_ready, busy, done, full, err_imm, err_op});
      end
      checks++;
      if (imem_addr !== '0 || imem_wdata !== '0 || words_written !== '0) begin
         failures++;
         $display("FAIL reset_data got addr=%h wdata=%h ww=%0d exp all 0", imem_addr, imem_wdata, words_written);
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_not_ready got ready=%b busy=%b exp 0 0", req_ready, busy);
      end
   endtask

   task automatic test_encode();
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b1 || words_written !== '0) begin
         failures++;
         $display("FAIL start_load got ready=%b busy=%b ww=%0d exp 1 1 0", req_ready, busy, words_written);
      end
      drive(T_ADDI, 1, 2, 0, 32'd5, 0); tick();
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== ADDR_W_T'(BASE_T) || imem_wdata !== 32'h91001441 || words_written !== 1) begin
         failures++;
         $display("FAIL addi got we=%b addr=%0d wdata=%h ww=%0d exp 1 %0d 91001441 1", imem_we, imem_addr, imem_wdata, words_written, BASE_T);
      end
      drive(T_ADDS, 3, 1, 2, 32'd0, 0); tick();
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== ADDR_W_T'(BASE_T + 1) || imem_wdata !== 32'hAB020023) begin
         failures++;
         $display("FAIL adds got we=%b addr=%0d wdata=%h exp 1 %0d ab020023", imem_we, imem_addr, imem_wdata, BASE_T + 1);
      end
      drive(T_B, 0, 0, 0, 32'hFFFF_FFFF, 0); tick();
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== ADDR_W_T'(BASE_T + 2) || imem_wdata !== 32'h17FFFFFF) begin
         failures++;
         $display("FAIL b_neg got we=%b addr=%0d wdata=%h exp 1 %0d 17ffffff", imem_we, imem_addr, imem_wdata, BASE_T + 2);
      end
      drive(T_CBZ, 0, 0, 0, 32'd2, 0); tick();
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== ADDR_W_T'(BASE_T + 3) || imem_wdata !== 32'hB4000040) begin
         failures++;
         $display("FAIL cbz got we=%b addr=%0d wdata=%h exp 1 %0d b4000040", imem_we, imem_addr, imem_wdata, BASE_T + 3);
      end
      checks++;
      if (full !== 1'b1 || done !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL full_same_cycle got full=%b done=%b ready=%b busy=%b exp 1 1 0 0", full, done, req_ready, busy);
      end
      drive(T_ADDI, 4, 4, 0, 32'd7, 0);
      repeat (3) begin
         tick();
         checks++;
         if (imem_we !== 1'b0 || words_written !== 4 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL after_full got we=%b ww=%0d ready=%b exp 0 4 0", imem_we, words_written, req_ready);
         end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_errors();
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (done !== 1'b0 || full !== 1'b0 || words_written !== '0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL restart_clear got done=%b full=%b ww=%0d ready=%b exp 0 0 0 1", done, full, words_written, req_ready);
      end
      drive(T_MOVZ, 5, 0, 0, 32'h0000_BEEF, 1); tick();
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== ADDR_W_T'(BASE_T) || imem_wdata !== 32'hD2B7DDE5) begin
         failures++;
         $display("FAIL movz got we=%b addr=%0d wdata=%h exp 1 %0d d2b7dde5", imem_we, imem_addr, imem_wdata, BASE_T);
      end
      drive(T_LDUR, 2, 3, 0, 32'd300, 0); tick();
      checks++;
      if (imem_we !== 1'b0 || err_imm !== 1'b1 || words_written !== 1) begin
         failures++;
         $display("FAIL ldur_range got we=%b err_imm=%b ww=%0d exp 0 1 1", imem_we, err_imm, words_written);
      end
      drive(T_STUR, 2, 3, 0, 32'hFFFF_FF00, 0); tick();
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== ADDR_W_T'(BASE_T + 1) || imem_wdata !== 32'hF8100062) begin
         failures++;
         $display("FAIL stur_min got we=%b addr=%0d wdata=%h exp 1 %0d f8100062", imem_we, imem_addr, imem_wdata, BASE_T + 1);
      end
      drive(T_BAD, 0, 0, 0, 32'd0, 0); tick();
      checks++;
      if (imem_we !== 1'b0 || err_op !== 1'b1 || err_imm !== 1'b1) begin
         failures++;
         $display("FAIL bad_op got we=%b err_op=%b err_imm=%b exp 0 1 1", imem_we, err_op, err_imm);
      end
      drive(T_END, 0, 0, 0, 32'd0, 0); tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b0 || full !== 1'b0 || imem_we !== 1'b0) begin
         failures++;
         $display("FAIL end got done=%b busy=%b ready=%b full=%b we=%b exp 1 0 0 0 0", done, busy, req_ready, full, imem_we);
      end
      req_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] w, imm_v;
      bit bad;
      int unsigned rd_v, rn_v;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rd_v = $urandom_range(0, 31); rn_v = $urandom_range(0, 31); imm_v = $urandom_range(0, 4095);
         drive(T_ADDI, rd_v, rn_v, 0, imm_v, 0);
         start = (i == 1);
         ref_encode(T_ADDI, rd_v, rn_v, 0, imm_v, 0, w, bad);
         tick();
         checks++;
         if (i < 4 && (imem_we !== 1'b1 || imem_addr !== ADDR_W_T'(BASE_T + i) || imem_wdata !== w)) begin
            failures++;
            $display("FAIL b2b_write%0d got we=%b addr=%0d wdata=%h exp 1 %0d %h", i, imem_we, imem_addr, imem_wdata, BASE_T + i, w);
         end else if (i == 4 && (imem_we !== 1'b0 || full !== 1'b1 || done !== 1'b1 || words_written !== 4)) begin
            failures++;
            $display("FAIL b2b_fifth got we=%b full=%b done=%b ww=%0d exp 0 1 1 4", imem_we, full, done, words_written);
         end
      end
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (full !== 1'b0 || done !== 1'b0 || words_written !== '0 || imem_we !== 1'b0) begin
         failures++;
         $display("FAIL b2b_restart got full=%b done=%b ww=%0d we=%b exp 0 0 0 0", full, done, words_written, imem_we);
      end
      tick();
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== ADDR_W_T'(BASE_T) || words_written !== 1) begin
         failures++;
         $display("FAIL b2b_base got we=%b addr=%0d ww=%0d exp 1 %0d 1", imem_we, imem_addr, words_written, BASE_T);
      end
      req_valid = 1'b0;
   endtask

   task automatic test_random();
      int op;
      for (int n = 0; n < 600; n++) begin
         start = (m_state != 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
         op = $urandom_range(0, 19);
         if (op >= 14 && op <= 17) op = $urandom_range(0, 13);
         else if (op == 18) op = T_BAD;
         else if (op == 19) op = T_END;
         drive(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), rand_imm(op),
               $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 63));
         req_valid = ($urandom_range(0, 9) < 7);
         tick();
         checks++;
         if (imem_we !== m_we || (m_we && (imem_addr !== m_addr[ADDR_W_T-1:0] || imem_wdata !== m_wdata))) begin
            failures++;
            $display("FAIL rnd_write n=%0d got we=%b addr=%0d wdata=%h exp %b %0d %h", n, imem_we, imem_addr, imem_wdata, m_we, m_addr, m_wdata);
         end
         checks++;
         if (words_written !== m_cnt[ADDR_W_T:0] || req_ready !== (m_state == 1) || busy !== (m_state == 1)
             || done !== (m_state == 2) || full !== m_full || err_imm !== m_eimm || err_op !== m_eop) begin
            failures++;
            $display("FAIL rnd_status n=%0d got ww=%0d rdy=%b busy=%b done=%b full=%b ei=%b eo=%b exp ww=%0d st=%0d full=%b ei=%b eo=%b",
                     n, words_written, req_ready, busy, done, full, err_imm, err_op, m_cnt, m_state, m_full, m_eimm, m_eop);
         end
      end
      start = 1'b0; req_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      start = 1'b1; tick(); start = 1'b0;
      drive(T_ADDI, 1, 1, 0, 32'd1, 0);
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({imem_we, req_ready, busy, done, full, err_imm, err_op} !== 7'b0 || words_written !== '0 || imem_addr !== '0) begin
         failures++;
         $display("FAIL reset_async got flags=%b ww=%0d addr=%0d exp 0", {imem_we, req_ready, busy, done, full, err_imm, err_op}, words_written, imem_addr);
      end
      repeat (2) begin
         tick();
         checks++;
         if (imem_we !== 1'b0 || imem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_hold got we=%b wdata=%h exp 0 0", imem_we, imem_wdata);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) begin
         tick();
         checks++;
         if (imem_we !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b0 || words_written !== '0) begin
            failures++;
            $display("FAIL reset_idle got we=%b ready=%b busy=%b ww=%0d exp 0 0 0 0", imem_we, req_ready, busy, words_written);
         end
      end
      req_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_encode();
      test_errors();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
